spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 24 ++
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Host command/read-back handshake plus the four-wire SPI pins of spi_master.
// The master modport is the controller's view; slave is the host/peripheral side.
interface spi_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO,
        output cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO,
        input  cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Single-clock SPI master: serialises an 11-bit command frame after a lead cycle,
// optionally turns around and receives one byte, then holds SS_n high for GAP cycles.
module spi_master #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned GAP    = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if.master  bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(10);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TURN, RECV, GAP_ST} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q;
    logic [7:0]       data_q;
    logic             ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rx_sr_q;
    logic [7:0]       rd_data_q;
    logic [10:0]      frame;
    logic             cmd_ready_c;
    logic             accept;

    // Handshake is combinational so a request can be taken on the first edge out of reset.
    assign cmd_ready_c = (state_q == IDLE) & ~rst;
    assign accept      = bus.cmd_valid & cmd_ready_c;
    assign frame       = {op_q[1], op_q, data_q};

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.busy      = (state_q != IDLE) & ~rst;
    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

    // State, counter and pin registers; pins are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state, per-state cycle counter and registered pin values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) state_d = LEAD;
            end
            LEAD: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d = '0;
                    if (op_q != 2'b11)    state_d = GAP_ST;
                    else if (RD_LAT == 0) state_d = RECV;
                    else                  state_d = TURN;
                end
            end
            TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (cnt_q == RECV_LAST) begin
                    cnt_d      = '0;
                    state_d    = GAP_ST;
                    rd_valid_d = 1'b1;
                end
            end
            GAP_ST: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        ss_n_d = !(state_d inside {LEAD, SHIFT, TURN, RECV});
        mosi_d = (state_d == SHIFT) ? frame[SHIFT_LAST - cnt_d] : 1'b0;
    end

    // Command capture and MSB-first receive shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 2'b00;
            data_q    <= 8'h00;
            rx_sr_q   <= 8'h00;
            rd_data_q <= 8'h00;
        end else begin
            if (accept) begin
                op_q   <= bus.cmd_op;
                data_q <= bus.cmd_data;
            end
            if (state_q == RECV) rx_sr_q   <= {rx_sr_q[6:0], bus.MISO};
            if (rd_valid_d)      rd_data_q <= {rx_sr_q[6:0], bus.MISO};
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + byte RAM on the pins.
module tb_spi_master;

    localparam int RD_LAT  = 1;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic miso = 1'b0;

    spi_master_if bus();
    assign bus.MISO = miso;

    spi_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Slave model state
    int          idx      = 0;
    int          last_len = 0;
    int          high_run = 0;
    int          last_gap = 0;
    int          rdv_cnt  = 0;
    logic [11:0] mosi_seq = 12'h000;
    logic [7:0]  mem [0:255];
    logic [7:0]  waddr    = 8'h00;
    logic [7:0]  raddr    = 8'h00;
    logic [7:0]  rbyte    = 8'h00;
    logic        ovr_en   = 1'b0;
    logic [7:0]  ovr_byte = 8'h00;

    // Slave: records the 12 MOSI bits (lead included), drives MISO in RECV, executes on SS_n rise.
    always @(negedge clk) begin
        if (bus.SS_n === 1'b0) begin
            if (idx == 0) last_gap = high_run;
            if (idx < 12) mosi_seq = {mosi_seq[10:0], bus.MOSI};
            if (idx >= 12 + RD_LAT && idx < 20 + RD_LAT && mosi_seq[9:8] == 2'b11) begin
                rbyte = ovr_en ? ovr_byte : mem[raddr];
                miso  = rbyte[7 - (idx - 12 - RD_LAT)];
            end else begin
                miso = 1'b0;
            end
            idx = idx + 1;
        end else begin
            if (idx != 0) begin
                last_len = idx;
                high_run = 0;
                case (mosi_seq[9:8])
                    2'b00:   waddr = mosi_seq[7:0];
                    2'b01:   mem[waddr] = mosi_seq[7:0];
                    2'b10:   raddr = mosi_seq[7:0];
                    default: ;
                endcase
            end
            idx      = 0;
            miso     = 1'b0;
            high_run = high_run + 1;
        end
    end

    always @(negedge clk) if (bus.rd_valid === 1'b1) rdv_cnt = rdv_cnt + 1;

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < TIMEOUT) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= TIMEOUT) begin
            n_total++;
            $display("FAIL %s: cmd_ready still %b after %0d cycles", tag, bus.cmd_ready, k);
        end
    endtask

    task automatic wait_ss_rise(input string tag);
        int k;
        k = 0;
        while (bus.SS_n !== 1'b1 && k < TIMEOUT) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= TIMEOUT) begin
            n_total++;
            $display("FAIL %s: SS_n still %b after %0d cycles", tag, bus.SS_n, k);
        end
    endtask

    // Present one request, return one cycle after it is accepted with the payload scrambled.
    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        wait_ready("issue");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_data  = ~data;
    endtask

    task automatic transact(input logic [1:0] op, input logic [7:0] data);
        issue(op, data);
        wait_ready("transact");
    endtask

    task automatic test_reset;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h11;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.SS_n !== 1'b1)       $display("FAIL rst_ss_n: got %b want 1", bus.SS_n); else n_pass++;
        n_total++; if (bus.MOSI !== 1'b0)       $display("FAIL rst_mosi: got %b want 0", bus.MOSI); else n_pass++;
        n_total++; if (bus.cmd_ready !== 1'b0)  $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); else n_pass++;
        n_total++; if (bus.busy !== 1'b0)       $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.rd_valid !== 1'b0)   $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_data !== 8'h00)   $display("FAIL rst_rd_data: got %h want 00", bus.rd_data); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (bus.cmd_ready !== 1'b1)  $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n_total++; if (bus.busy !== 1'b1)       $display("FAIL first_edge_accept: busy got %b want 1", bus.busy); else n_pass++;
        n_total++; if (bus.SS_n !== 1'b0)       $display("FAIL first_edge_lead: SS_n got %b want 0", bus.SS_n); else n_pass++;
        wait_ready("reset_frame");
    endtask

    task automatic test_write_addr;
        int c;
        issue(2'b00, 8'hD7);
        wait_ss_rise("wa_rise");
        n_total++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0)
            $display("FAIL wa_gap_busy: busy=%b ready=%b want 1/0", bus.busy, bus.cmd_ready); else n_pass++;
        c = 0;
        while (bus.cmd_ready !== 1'b1 && c < TIMEOUT) begin
            @(posedge clk); #1;
            c++;
        end
        n_total++; if (c != GAP)                $display("FAIL wa_gap_len: ready after %0d want %0d", c, GAP); else n_pass++;
        n_total++; if (bus.SS_n !== 1'b1)       $display("FAIL wa_idle_ss_n: got %b want 1", bus.SS_n); else n_pass++;
        n_total++; if (last_len != 12)          $display("FAIL wa_len: got %0d want 12", last_len); else n_pass++;
        n_total++; if (mosi_seq !== 12'h0D7)    $display("FAIL wa_mosi: got %h want 0d7", mosi_seq); else n_pass++;
        n_total++; if (waddr !== 8'hD7)         $display("FAIL wa_slave_addr: got %h want d7", waddr); else n_pass++;
    endtask

    task automatic test_write_data;
        int rdv0;
        rdv0 = rdv_cnt;
        transact(2'b01, 8'hC9);
        n_total++; if (mosi_seq !== 12'h1C9)    $display("FAIL wd_mosi: got %h want 1c9", mosi_seq); else n_pass++;
        n_total++; if (last_len != 12)          $display("FAIL wd_len: got %0d want 12", last_len); else n_pass++;
        n_total++; if (rdv_cnt != rdv0)         $display("FAIL wd_no_rd_valid: got %0d pulses want 0", rdv_cnt - rdv0); else n_pass++;
        n_total++; if (mem[8'hD7] !== 8'hC9)    $display("FAIL wd_slave_mem: got %h want c9", mem[8'hD7]); else n_pass++;
    endtask

    task automatic test_read_data;
        int rdv0;
        ovr_en   = 1'b1;
        ovr_byte = 8'hA5;
        rdv0     = rdv_cnt;
        transact(2'b11, 8'h3C);
        ovr_en = 1'b0;
        n_total++; if (last_len != 21)          $display("FAIL rd_len: got %0d want 21", last_len); else n_pass++;
        n_total++; if (mosi_seq !== 12'h73C)    $display("FAIL rd_mosi: got %h want 73c", mosi_seq); else n_pass++;
        n_total++; if (rdv_cnt != rdv0 + 1)     $display("FAIL rd_valid_pulses: got %0d want 1", rdv_cnt - rdv0); else n_pass++;
        n_total++; if (bus.rd_data !== 8'hA5)   $display("FAIL rd_data: got %h want a5", bus.rd_data); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int c;
        wait_ready("b2b_start");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h3C;
        @(posedge clk); #1;
        bus.cmd_op    = 2'b01;
        bus.cmd_data  = 8'h5A;
        wait_ss_rise("b2b_rise");
        c = 0;
        while (bus.cmd_ready !== 1'b1 && c < TIMEOUT) begin
            @(posedge clk); #1;
            c++;
        end
        n_total++; if (c != GAP)                $display("FAIL b2b_accept_gap: ready after %0d want %0d", c, GAP); else n_pass++;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n_total++; if (bus.SS_n !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL b2b_second_accept: SS_n=%b busy=%b want 0/1", bus.SS_n, bus.busy); else n_pass++;
        wait_ready("b2b_end");
        n_total++; if (last_gap != GAP + 1)     $display("FAIL b2b_ss_high: got %0d want %0d", last_gap, GAP + 1); else n_pass++;
        n_total++; if (mem[8'h3C] !== 8'h5A)    $display("FAIL b2b_slave_mem: got %h want 5a", mem[8'h3C]); else n_pass++;
        n_total++; if (bus.rd_data !== 8'hA5)   $display("FAIL b2b_rd_data_hold: got %h want a5", bus.rd_data); else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        int rdv0;
        ovr_en   = 1'b1;
        ovr_byte = 8'hFF;
        rdv0     = rdv_cnt;
        issue(2'b11, 8'h00);
        repeat (17) @(posedge clk);
        #1;
        n_total++; if (bus.SS_n !== 1'b0)       $display("FAIL mr_in_recv: SS_n got %b want 0", bus.SS_n); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.SS_n !== 1'b1)       $display("FAIL mr_ss_n: got %b want 1", bus.SS_n); else n_pass++;
        n_total++; if (bus.rd_data !== 8'h00)   $display("FAIL mr_rd_data_rst: got %h want 00", bus.rd_data); else n_pass++;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        ovr_en = 1'b0;
        n_total++; if (rdv_cnt != rdv0)         $display("FAIL mr_no_rd_valid: got %0d pulses want 0", rdv_cnt - rdv0); else n_pass++;
        n_total++; if (bus.rd_data !== 8'h00)   $display("FAIL mr_rd_data: got %h want 00", bus.rd_data); else n_pass++;
        n_total++; if (bus.cmd_ready !== 1'b1)  $display("FAIL mr_ready: got %b want 1", bus.cmd_ready); else n_pass++;
    endtask

    task automatic test_end_to_end;
        int rdv0;
        rdv0 = rdv_cnt;
        transact(2'b00, 8'h57);
        transact(2'b01, 8'hC9);
        transact(2'b10, 8'h57);
        transact(2'b11, 8'h00);
        n_total++; if (raddr !== 8'h57)         $display("FAIL e2e_raddr: got %h want 57", raddr); else n_pass++;
        n_total++; if (rdv_cnt != rdv0 + 1)     $display("FAIL e2e_pulses: got %0d want 1", rdv_cnt - rdv0); else n_pass++;
        n_total++; if (bus.rd_data !== 8'hC9)   $display("FAIL e2e_rd_data: got %h want c9", bus.rd_data); else n_pass++;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        test_reset;
        test_write_addr;
        test_write_data;
        test_read_data;
        test_back_to_back;
        test_reset_mid_read;
        test_end_to_end;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
